// File: rtl/timebase_pkg.sv
// Shared definitions for the timebase controller: FSM encoding, channel count
// and the power-up divide ratio of each channel.
package timebase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int NUM_CH = 3;

    localparam int DIV0_DEFAULT = 500;
    localparam int DIV1_DEFAULT = 1000;
    localparam int DIV2_DEFAULT = 4;

    function automatic int default_div(input int ch);
        case (ch)
            0:       return DIV0_DEFAULT;
            1:       return DIV1_DEFAULT;
            default: return DIV2_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/tb_channel.sv
// One timebase output channel: divide register, base-tick counter and the
// registered tick pulse.
module tb_channel #(
    parameter int               DIV_W     = 10,
    parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wrap,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;

    // A write restarts the count, so a wrap landing on the write edge is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div  <= RESET_DIV;
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (we)
                div <= wdata;
            if (clr || we) begin
                cnt <= '0;
            end else if (wrap && div != '0) begin
                if (cnt == div - DIV_W'(1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timebase_ctrl.sv
// Programmable timebase: shared prescaler under a start/pause/clear FSM feeding
// three independently divided tick channels plus a square-wave output.
module timebase_ctrl
    import timebase_pkg::*;
#(
    parameter int BASE_DIV = 100000,
    parameter int DIV_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [2:0]       tick,
    output logic             base_tick,
    output logic             sq_out,
    output logic [1:0]       state
);

    localparam int             PW        = $clog2(BASE_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(BASE_DIV - 1);

    state_t         state_q;
    state_t         state_d;
    logic [PW-1:0]  presc;
    logic           wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Pause outranks start even where pause itself has no effect.
    always_comb begin
        state_d = state_q;
        wrap    = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (pause) begin
            if (state_q == ST_RUN)
                state_d = ST_PAUSE;
        end else if (start && state_q != ST_RUN) begin
            state_d = ST_RUN;
        end
        if (state_q == ST_RUN && presc == PRESC_MAX && !clear)
            wrap = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= wrap;
            if (clear)
                presc <= '0;
            else if (state_q == ST_RUN)
                presc <= wrap ? '0 : presc + PW'(1);
        end
    end

    // sq_out deliberately survives clear; only reset returns it to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sq_out <= 1'b0;
        else if (tick[0])
            sq_out <= ~sq_out;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tb_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DIV_W'(default_div(i)))
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .wrap  (wrap),
            .we    (cfg_we && cfg_sel == 2'(i)),
            .wdata (cfg_div),
            .tick  (tick[i])
        );
    end

    assign state = state_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl with a 4-cycle prescaler; expected tick
// positions are hand-derived cycle offsets from the start or write edge.
module tb_timebase_ctrl;

    localparam int BASE_DIV = 4;
    localparam int DIV_W    = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             clear = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_sel = 2'd0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [2:0]       tick;
    logic             base_tick;
    logic             sq_out;
    logic [1:0]       state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    timebase_ctrl #(
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .base_tick (base_tick),
        .sq_out    (sq_out),
        .state     (state)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Lines a config write up with the next prescaler wrap edge.
    task automatic write_at_wrap(input logic [1:0] sel, input logic [DIV_W-1:0] div,
                                 output int w_cyc);
        int waited = 0;
        while (base_tick !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (base_tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL write_sync: base_tick=%b required 1 within 40 cycles", base_tick);
        end
        idle(BASE_DIV - 1);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_div = div;
        @(negedge clk);
        cfg_we = 1'b0;
        w_cyc  = cyc;
    endtask

    task automatic test_reset();
        int bad = 0;
        #1;
        n_checks++;
        if (state !== 2'd0 || tick !== 3'b000 || base_tick !== 1'b0 || sq_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: state=%0d tick=%b base=%b sq=%b required 0/000/0/0",
                     state, tick, base_tick, sq_out);
        end
        idle(2);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (state !== 2'd0 || base_tick !== 1'b0 || tick !== 3'b000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_quiet: %0d active cycles in IDLE, required 0", bad);
        end
    endtask

    task automatic test_defaults();
        int bad_base = 0, bad_t0 = 0, bad_t1 = 0, bad_t2 = 0, bad_sq = 0;
        pulse_start();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL start_run: state=%0d required 1", state);
        end
        for (int k = 1; k <= 2004; k++) begin
            @(negedge clk);
            if (base_tick !== (k % 4 == 0))  bad_base++;
            if (tick[2]   !== (k % 16 == 0)) bad_t2++;
            if (tick[0]   !== (k == 2000))   bad_t0++;
            if (tick[1]   !== 1'b0)          bad_t1++;
            if (sq_out    !== (k > 2000))    bad_sq++;
        end
        n_checks++;
        if (bad_base != 0) begin
            n_fail++;
            $display("[TB] FAIL default_base_tick: %0d wrong cycles, required 0", bad_base);
        end
        n_checks++;
        if (bad_t2 != 0) begin
            n_fail++;
            $display("[TB] FAIL default_tick2: %0d wrong cycles, required 0", bad_t2);
        end
        n_checks++;
        if (bad_t0 != 0) begin
            n_fail++;
            $display("[TB] FAIL default_tick0: %0d wrong cycles, required 0", bad_t0);
        end
        n_checks++;
        if (bad_t1 != 0) begin
            n_fail++;
            $display("[TB] FAIL default_tick1: %0d wrong cycles, required 0", bad_t1);
        end
        n_checks++;
        if (bad_sq != 0) begin
            n_fail++;
            $display("[TB] FAIL default_sq_out: %0d wrong cycles, required 0", bad_sq);
        end
    endtask

    task automatic test_cfg_write();
        int w, bad = 0;
        write_at_wrap(2'd1, DIV_W'(3), w);
        n_checks++;
        if (tick[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cfg1_write_edge: tick1=%b required 0", tick[1]);
        end
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (tick[1] !== (k % 12 == 0)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL cfg1_period12: %0d wrong cycles, required 0", bad);
        end
    endtask

    task automatic test_pause();
        int t1, t2, t3, waited, bad = 0;
        waited = 0;
        while (tick[2] !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        t1 = cyc;
        idle(5);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL pause_state: state=%0d required 2", state);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (base_tick !== 1'b0 || tick !== 3'b000) bad++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (base_tick !== 1'b0 || tick !== 3'b000) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL pause_frozen: %0d active cycles, required 0", bad);
        end
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL resume_state: state=%0d required 1", state);
        end
        waited = 0;
        while (tick[2] !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        t2 = cyc;
        n_checks++;
        if (t2 - t1 != 21) begin
            n_fail++;
            $display("[TB] FAIL pause_spacing: tick2 gap=%0d required 21", t2 - t1);
        end
        @(negedge clk);
        waited = 0;
        while (tick[2] !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
        t3 = cyc;
        n_checks++;
        if (t3 - t2 != 16) begin
            n_fail++;
            $display("[TB] FAIL post_pause_spacing: tick2 gap=%0d required 16", t3 - t2);
        end
    endtask

    task automatic test_clear_priority();
        int bad = 0;
        clear = 1'b1;
        pause = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        n_checks++;
        if (state !== 2'd0 || tick !== 3'b000 || base_tick !== 1'b0 || sq_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_priority: state=%0d tick=%b base=%b sq=%b required 0/000/0/1",
                     state, tick, base_tick, sq_out);
        end
        idle(3);
        pulse_start();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (base_tick !== (k % 4 == 0)) bad++;
            if (tick[1] !== (k == 12)) bad++;
            if (tick[2] !== (k == 16)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL clear_counters_zeroed: %0d wrong samples, required 0", bad);
        end
        n_checks++;
        if (sq_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_sq_retained: sq=%b required 1", sq_out);
        end
    endtask

    task automatic test_div_zero_one();
        int w, bad = 0;
        write_at_wrap(2'd2, DIV_W'(0), w);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (tick[2] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL div0_disabled: %0d tick2 pulses, required 0", bad);
        end
        write_at_wrap(2'd2, DIV_W'(1), w);
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (tick[2] !== (k % 4 == 0) || base_tick !== (k % 4 == 0)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL div1_pattern: %0d wrong cycles, required 0", bad);
        end
        write_at_wrap(2'd2, DIV_W'(1), w);
        n_checks++;
        if (tick[2] !== 1'b0 || base_tick !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL write_suppress: tick2=%b base=%b required 0/1", tick[2], base_tick);
        end
        bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (tick[2] !== (k % 4 == 0)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL div1_after_rewrite: %0d wrong cycles, required 0", bad);
        end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        idle(2);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'd0 || tick !== 3'b000 || base_tick !== 1'b0 || sq_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: state=%0d tick=%b base=%b sq=%b required 0/000/0/0",
                     state, tick, base_tick, sq_out);
        end
        idle(2);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (state !== 2'd0 || tick !== 3'b000 || base_tick !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_partial: %0d active cycles, required 0", bad);
        end
        pulse_start();
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (base_tick !== (k % 4 == 0)) bad++;
            if (tick !== {(k == 16), 2'b00}) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_div_defaults: %0d wrong samples, required 0", bad);
        end
    endtask

    initial begin
        $display("[TB] timebase_ctrl directed test, BASE_DIV=%0d", BASE_DIV);
        test_reset();
        test_defaults();
        test_cfg_write();
        test_pause();
        test_clear_priority();
        test_div_zero_one();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 SHALL have parameter BASE_DIV, default 100000, meaning clk cycles per base tick (1 kHz at 100 MHz); legal range 2..2^26.
REQ-002 SHALL have parameter DIV_W, default 10, meaning width of per-channel divide registers.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to enter or resume RUN.
REQ-006 SHALL have port pause, input, 1, single-cycle request to freeze counting.
REQ-007 SHALL have port clear, input, 1, single-cycle request to return to IDLE and zero all counters.
REQ-008 SHALL have port cfg_we, input, 1, write strobe for a channel divide register.
REQ-009 SHALL have port cfg_sel, input, 2, channel index 0..2; value 3 ignored.
REQ-010 SHALL have port cfg_div, input, DIV_W, divide ratio in base ticks; 0 disables the channel.
REQ-011 SHALL have port tick, output, 3, per-channel one-cycle pulses.
REQ-012 SHALL have port base_tick, output, 1, one-cycle pulse at each prescaler wrap.
REQ-013 SHALL have port sq_out, output, 1, square wave toggling on every tick[0].
REQ-014 SHALL have port state, output, 2, FSM state: 0 IDLE, 1 RUN, 2 PAUSE.

Function
REQ-015 SHALL implement FSM IDLE/RUN/PAUSE: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -start-> RUN; any state -clear-> IDLE.
REQ-016 SHALL resolve simultaneous requests with priority clear > pause > start; start in RUN and pause in IDLE/PAUSE are no-ops.
REQ-017 SHALL, in RUN only, count the shared prescaler 0..BASE_DIV-1 and wrap to 0, asserting base_tick for the one cycle after the edge at which the count was BASE_DIV-1.
REQ-018 SHALL give channel i a counter 0..div_i-1 advanced once per prescaler wrap; tick[i] SHALL be high for the one cycle after the edge at which that wrap and count div_i-1 coincide, the counter returning to 0.
REQ-019 SHALL produce first tick[i] exactly BASE_DIV*div_i clk cycles after the start-accepting edge from IDLE.
REQ-020 SHALL hold no tick and keep counter at 0 for a channel with div_i = 0; div_i = 1 SHALL tick on every base_tick.
REQ-021 SHALL freeze prescaler and channel counts in PAUSE and resume from the frozen values, with no lost or extra ticks.
REQ-022 SHALL, on clear, zero prescaler and channel counters and deassert tick/base_tick next cycle; divide registers and sq_out SHALL be retained.
REQ-023 SHALL, on cfg_we with cfg_sel<=2, load div[cfg_sel] and zero that channel counter at the same edge, in any state; a write coinciding with that channel's wrap SHALL suppress that tick.
REQ-024 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-025 SHALL toggle sq_out at the edge after each tick[0] pulse (50% duty, period 2*BASE_DIV*div_0).

Reset
REQ-026 SHALL on rst low asynchronously force state=IDLE, prescaler and counters 0, tick=0, base_tick=0, sq_out=0.
REQ-027 SHALL reset div_0=500, div_1=1000, div_2=4 (1 Hz sq_out, 1 Hz tick[1], 250 Hz tick[2] at default BASE_DIV and 100 MHz).
REQ-028 SHALL abort any operation on reset mid-run with no partial pulse after release.

Structure
REQ-029 SHALL place state encoding, channel count (3) and default divide values in shared package timebase_pkg.
REQ-030 SHALL instantiate sub-module tb_channel three times (divide register, counter, tick register); prescaler and FSM reside in top.

Verification (BASE_DIV=4 in simulation)
REQ-031 Reset, start; div defaults -> base_tick every 4 cycles, first tick[2] 16 cycles after start, tick[0] every 2000 cycles.
REQ-032 Write cfg_sel=1, div=3 in RUN -> tick[1] every 12 cycles counted from the write edge.
REQ-033 Pause 5 cycles mid-period, then start -> tick[2] spacing grows by exactly 5 cycles, no duplicate tick.
REQ-034 clear, pause, start all high in one cycle while RUN -> state=IDLE, counters 0, sq_out retained.
REQ-035 Write cfg_sel=2, div=0 -> tick[2] stays 0; write div=1 -> tick[2] equals base_tick pattern.
REQ-036 Assert rst low mid-RUN between edges -> all outputs 0 immediately, state=IDLE, divs back to 500/1000/4.
